adpcm_mac_pipe: RTL and testbench
=================================

Name: adpcm_mac_pipe

Overview:
Parametrised, pipelined signed multiply-accumulate unit for the ADPCM datapath. It generalises the fixed two-cycle product multiplier in four ways: configurable pipeline depth, valid/ready flow control with backpressure, an optional running accumulator, and rounding-shift plus saturation on the output. It sits between the predictor/quantiser stages and consumes their operand streams directly.

Parameters:
- DIN0_WIDTH, 32, signed width of operand din0.
- DIN1_WIDTH, 13, signed width of operand din1.
- ACC_WIDTH, 48, accumulator width. Must be >= DIN0_WIDTH+DIN1_WIDTH.
- DOUT_WIDTH, 32, signed output width.
- SHIFT, 0, arithmetic right shift applied to the accumulator before output. Range 0..ACC_WIDTH-1.
- NUM_STAGE, 2, pipeline depth from accept to out_valid. Range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  global clock enable; 0 freezes all state.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- din0  in  DIN0_WIDTH  signed operand.
- din1  in  DIN1_WIDTH  signed operand.
- acc_en  in  1  1 = add product to accumulator; 0 = load accumulator with product.
- out_valid  out  1  dout/sat valid.
- out_ready  in  1  consumer accepts output.
- dout  out  DOUT_WIDTH  rounded, shifted, saturated accumulator value.
- sat  out  1  dout was clamped for this result.

Behaviour:
- Product: full precision, signed(din0)*signed(din1), width P=DIN0_WIDTH+DIN1_WIDTH, sign-extended to ACC_WIDTH.
- Pipeline: NUM_STAGE register stages. Each stage holds a valid bit, product and acc_en.
  - Stage 1 captures the product at accept.
  - The final stage is the output register.
- Advance condition: adv = ce & (~out_valid | out_ready).
  - in_ready = adv (combinational).
  - Accept = in_valid & in_ready.
- Global stall: when adv=0, every stage, the accumulator and the outputs hold.
  - Bubbles (invalid stages) are not collapsed.
  - Order is preserved; no operand is dropped or duplicated.
- Accumulator update: happens only when a valid entry moves into the output register.
  - acc_en=1: acc <= acc + product, wrapping modulo 2^ACC_WIDTH.
  - acc_en=0: acc <= product.
  - Invalid entries leave acc unchanged.
- Output computation, from the new acc value:
  - If SHIFT>0: r = (acc_new + 2^(SHIFT-1)) >>> SHIFT (round half up), computed in ACC_WIDTH+1 bits so the add cannot overflow.
  - If SHIFT=0: r = acc_new.
  - If r > 2^(DOUT_WIDTH-1)-1 → dout = max, sat=1.
  - If r < -2^(DOUT_WIDTH-1) → dout = min, sat=1.
  - Otherwise dout = r[DOUT_WIDTH-1:0], sat=0.
- Latency: out_valid rises exactly NUM_STAGE adv-cycles after accept. Throughput is 1 result per cycle when out_ready=1.
- out_valid drops on an advance with an invalid entry in the previous stage. dout and sat hold their last values when out_valid=0.
- Simultaneous output handshake and input accept in the same cycle is legal and required for full throughput.
- Reset (asserted low, asynchronous):
  - All valid bits = 0, acc = 0, dout = 0, sat = 0.
  - out_valid = 0; in_ready follows adv and is therefore ce.
  - Reset mid-operation discards all in-flight entries and the accumulator. The first operand accepted after reset is treated as acc_en=0 regardless of the pin.
- ce=0 with in_valid=1: not accepted (in_ready=0).

Test Plan:
1. Defaults, din0=-3, din1=7, acc_en=0, out_ready=1 → out_valid exactly 2 cycles after accept, dout=-21, sat=0.
2. SHIFT=4 with acc_en=0:
   - 100*1 → dout=6.
   - -24*1 → dout=-1.
   - 8*1 → dout=1 (half rounds up).
3. DOUT_WIDTH=16, SHIFT=0:
   - 32767*4095 → dout=32767, sat=1.
   - -32768*4095 → dout=-32768, sat=1.
   - 100*100 → dout=10000, sat=0.
4. Back-to-back stream (10,10,acc_en=0), (5,4,1), (-2,3,1), (1,1,0) → dout 100, 120, 114, 1 on consecutive cycles.
5. Stream of 6 ops with out_ready held low for 3 cycles after the first result:
   - in_ready=0 during the stall.
   - No input accepted during the stall.
   - All 6 results delivered in order with correct values.
   - dout stable while out_valid & ~out_ready.
6. NUM_STAGE=1 and NUM_STAGE=4 each run test 4 → latency 1 and 4 cycles respectively. Then assert reset with 2 ops in flight → out_valid=0 immediately, no stale result afterwards, next op (7,3,acc_en=1) gives dout=21.

Source files
------------

// File: rtl/adpcm_mac_pipe.sv
// adpcm_mac_pipe
// Pipelined signed multiply-accumulate unit for the ADPCM datapath.
// din0*din1 is formed at full precision and carried through NUM_STAGE
// register stages. The last stage is the output register: it updates
// the running accumulator, then rounds, shifts and saturates the result.
// Valid/ready flow control uses a single global advance, so a stalled
// output freezes the whole pipe.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   ce         clock enable; 0 freezes all state
//   in_valid   operand pair valid
//   in_ready   pair accepted this cycle when in_valid is also high
//   din0/din1  signed operands
//   acc_en     1: accumulate the product, 0: load the product
//   out_valid  dout/sat hold a result
//   out_ready  consumer takes the result
//   dout       rounded, shifted, saturated accumulator
//   sat        dout was clamped
module adpcm_mac_pipe #(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 13,
  parameter int ACC_WIDTH  = 48,
  parameter int DOUT_WIDTH = 32,
  parameter int SHIFT      = 0,
  parameter int NUM_STAGE  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  sat
);

  localparam int P = DIN0_WIDTH + DIN1_WIDTH;

  // Clamp limits expressed at the width of the rounded value so the
  // comparisons are plain signed compares.
  localparam logic signed [ACC_WIDTH:0] R_MAX =
    {{(ACC_WIDTH + 2 - DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] R_MIN =
    {{(ACC_WIDTH + 2 - DOUT_WIDTH){1'b1}}, {(DOUT_WIDTH - 1){1'b0}}};

  logic                        adv;
  logic                        accept;
  logic signed [P-1:0]         prod_in;
  logic                        feed_v;
  logic                        feed_ae;
  logic signed [P-1:0]         feed_p;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_new;
  logic signed [ACC_WIDTH:0]   rnd;
  logic [DOUT_WIDTH-1:0]       dout_n;
  logic                        sat_n;

  // One advance signal for the whole pipe: bubbles are kept, not squeezed.
  assign adv      = ce & (~out_valid | out_ready);
  assign in_ready = adv;
  assign accept   = in_valid & adv;
  assign prod_in  = P'($signed(din0)) * P'($signed(din1));

  // feed_* is the entry that moves into the output register on adv.
  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign feed_v  = accept;
      assign feed_p  = prod_in;
      assign feed_ae = acc_en;
    end else begin : g_pipe
      logic [NUM_STAGE-2:0]        v_q;
      logic [NUM_STAGE-2:0]        ae_q;
      logic [NUM_STAGE-2:0][P-1:0] p_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          v_q  <= '0;
          ae_q <= '0;
          p_q  <= '0;
        end else if (adv) begin
          v_q[0]  <= accept;
          ae_q[0] <= acc_en;
          p_q[0]  <= prod_in;
          for (int i = 1; i < NUM_STAGE - 1; i++) begin
            v_q[i]  <= v_q[i-1];
            ae_q[i] <= ae_q[i-1];
            p_q[i]  <= p_q[i-1];
          end
        end
      end

      assign feed_v  = v_q[NUM_STAGE-2];
      assign feed_ae = ae_q[NUM_STAGE-2];
      assign feed_p  = $signed(p_q[NUM_STAGE-2]);
    end
  endgenerate

  assign prod_ext = ACC_WIDTH'(feed_p);
  // acc is zero out of reset, so the first accumulate after reset is a load.
  assign acc_new  = feed_ae ? (acc_q + prod_ext) : prod_ext;

  // Round half up, done one bit wider so adding the half LSB cannot wrap.
  generate
    if (SHIFT == 0) begin : g_noshift
      assign rnd = (ACC_WIDTH + 1)'(acc_new);
    end else begin : g_shift
      localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(1) << (SHIFT - 1);
      assign rnd = ((ACC_WIDTH + 1)'(acc_new) + HALF) >>> SHIFT;
    end
  endgenerate

  always_comb begin
    dout_n = rnd[DOUT_WIDTH-1:0];
    sat_n  = 1'b0;
    if (rnd > R_MAX) begin
      dout_n = R_MAX[DOUT_WIDTH-1:0];
      sat_n  = 1'b1;
    end else if (rnd < R_MIN) begin
      dout_n = R_MIN[DOUT_WIDTH-1:0];
      sat_n  = 1'b1;
    end
  end

  // Output register; dout/sat keep the last result while out_valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      acc_q     <= '0;
      dout      <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      out_valid <= feed_v;
      if (feed_v) begin
        acc_q <= acc_new;
        dout  <= dout_n;
        sat   <= sat_n;
      end
    end
  end

endmodule

// File: tb/tb_adpcm_mac_pipe.sv
module tb_adpcm_mac_pipe;

  typedef struct {
    int     sel;   // 0 def, 1 shift4, 2 dout16, 3 stage1, 4 stage4
    int     a;
    int     b;
    longint exp;
    bit     s;
    int     lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        acc_en = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] din0 = '0;
  logic [12:0] din1 = '0;

  logic        ir_def, ov_def, sat_def;
  logic [31:0] dout_def;
  logic        ir_sh4, ov_sh4, sat_sh4;
  logic [31:0] dout_sh4;
  logic        ir_w16, ov_w16, sat_w16;
  logic [15:0] dout_w16;
  logic        ir_n1, ov_n1, sat_n1;
  logic [31:0] dout_n1;
  logic        ir_n4, ov_n4, sat_n4;
  logic [31:0] dout_n4;

  adpcm_mac_pipe u_def (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(ir_def),
    .din0(din0), .din1(din1), .acc_en(acc_en), .out_valid(ov_def),
    .out_ready(out_ready), .dout(dout_def), .sat(sat_def));

  adpcm_mac_pipe #(.SHIFT(4)) u_sh4 (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(ir_sh4),
    .din0(din0), .din1(din1), .acc_en(acc_en), .out_valid(ov_sh4),
    .out_ready(out_ready), .dout(dout_sh4), .sat(sat_sh4));

  adpcm_mac_pipe #(.DOUT_WIDTH(16)) u_w16 (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(ir_w16),
    .din0(din0), .din1(din1), .acc_en(acc_en), .out_valid(ov_w16),
    .out_ready(out_ready), .dout(dout_w16), .sat(sat_w16));

  adpcm_mac_pipe #(.NUM_STAGE(1)) u_n1 (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(ir_n1),
    .din0(din0), .din1(din1), .acc_en(acc_en), .out_valid(ov_n1),
    .out_ready(out_ready), .dout(dout_n1), .sat(sat_n1));

  adpcm_mac_pipe #(.NUM_STAGE(4)) u_n4 (
    .clk(clk), .reset(rst_n), .ce(ce), .in_valid(in_valid), .in_ready(ir_n4),
    .din0(din0), .din1(din1), .acc_en(acc_en), .out_valid(ov_n4),
    .out_ready(out_ready), .dout(dout_n4), .sat(sat_n4));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output collectors: a result counts when seen valid with out_ready high.
  longint q_def[$], q_n1[$], q_n4[$];
  int     c_def[$], c_n1[$], c_n4[$];
  always @(negedge clk) begin
    if (ov_def && out_ready) begin q_def.push_back(longint'($signed(dout_def))); c_def.push_back(cyc); end
    if (ov_n1 && out_ready)  begin q_n1.push_back(longint'($signed(dout_n1)));   c_n1.push_back(cyc);  end
    if (ov_n4 && out_ready)  begin q_n4.push_back(longint'($signed(dout_n4)));   c_n4.push_back(cyc);  end
  end

  int     sel = 0;
  logic   s_ov, s_ir, s_sat;
  longint s_dout;
  always_comb begin
    s_ov = ov_def; s_ir = ir_def; s_sat = sat_def; s_dout = longint'($signed(dout_def));
    case (sel)
      1: begin s_ov = ov_sh4; s_ir = ir_sh4; s_sat = sat_sh4; s_dout = longint'($signed(dout_sh4)); end
      2: begin s_ov = ov_w16; s_ir = ir_w16; s_sat = sat_w16; s_dout = longint'($signed(dout_w16)); end
      3: begin s_ov = ov_n1;  s_ir = ir_n1;  s_sat = sat_n1;  s_dout = longint'($signed(dout_n1));  end
      4: begin s_ov = ov_n4;  s_ir = ir_n4;  s_sat = sat_n4;  s_dout = longint'($signed(dout_n4));  end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_q();
    q_def.delete(); q_n1.delete(); q_n4.delete();
    c_def.delete(); c_n1.delete(); c_n4.delete();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    sel = v.sel;
    @(posedge clk); #1;
    in_valid = 1'b1; din0 = v.a; din1 = 13'(v.b); acc_en = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_in_ready", idx), longint'(s_ir), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!s_ov && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, v.lat);
    chk($sformatf("vec%0d_dout", idx), s_dout, v.exp);
    chk($sformatf("vec%0d_sat", idx), longint'(s_sat), longint'(v.s));
    repeat (6) @(posedge clk);
  endtask

  int op_a[6], op_b[6];
  bit op_e[6];

  // Drives n ops on consecutive cycles; returns the cycle stamp of the first accept.
  task automatic drive_stream(input int n, output int a0);
    a0 = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) a0 = cyc + 1;
      in_valid = 1'b1; din0 = op_a[k]; din1 = 13'(op_b[k]); acc_en = op_e[k];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_stream(input string nm, input longint vals[$], input int stamps[$],
                            input int a0, input int lat);
    longint ev[4] = '{100, 120, 114, 1};
    chk({nm, "_count"}, vals.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < vals.size()) begin
        chk($sformatf("%s_val%0d", nm, i), vals[i], ev[i]);
        chk($sformatf("%s_cyc%0d", nm, i), stamps[i], a0 + lat - 1 + i);
      end
    end
  endtask

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0;
    int g;
    int k;
    longint exp5[6];

    tbl[0]  = '{0, -3, 7, -21, 1'b0, 2};
    tbl[1]  = '{0, -1, -4096, 4096, 1'b0, 2};
    tbl[2]  = '{1, 100, 1, 6, 1'b0, 2};
    tbl[3]  = '{1, -24, 1, -1, 1'b0, 2};
    tbl[4]  = '{1, 8, 1, 1, 1'b0, 2};
    tbl[5]  = '{1, -8, 1, 0, 1'b0, 2};
    tbl[6]  = '{1, 7, 1, 0, 1'b0, 2};
    tbl[7]  = '{2, 32767, 4095, 32767, 1'b1, 2};
    tbl[8]  = '{2, -32768, 4095, -32768, 1'b1, 2};
    tbl[9]  = '{2, 100, 100, 10000, 1'b0, 2};
    tbl[10] = '{2, 32767, 1, 32767, 1'b0, 2};
    tbl[11] = '{2, -32768, 1, -32768, 1'b0, 2};
    tbl[12] = '{2, 32768, 1, 32767, 1'b1, 2};
    tbl[13] = '{2, -32769, 1, -32768, 1'b1, 2};
    tbl[14] = '{3, 10, 10, 100, 1'b0, 1};
    tbl[15] = '{4, 10, 10, 100, 1'b0, 4};

    // Reset state
    #12;
    chk("rst_out_valid", longint'(ov_def), 0);
    chk("rst_dout", longint'(dout_def), 0);
    chk("rst_sat", longint'(sat_def), 0);
    chk("rst_in_ready_ce1", longint'(ir_def), 1);
    ce = 1'b0; #1;
    chk("rst_in_ready_ce0", longint'(ir_def), 0);
    ce = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;

    // ce=0 blocks acceptance
    clear_q();
    @(posedge clk); #1;
    ce = 1'b0; in_valid = 1'b1; din0 = 5; din1 = 13'(5);
    repeat (3) begin
      @(negedge clk);
      chk("ce0_in_ready", longint'(ir_def), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; ce = 1'b1;
    repeat (6) @(posedge clk);
    chk("ce0_no_result", q_def.size(), 0);

    // Single-op table
    for (int i = 0; i < 16; i++) run_vec(i, tbl[i]);
    sel = 0;

    // Back-to-back stream on default, 1-stage and 4-stage pipes
    op_a[0] = 10; op_b[0] = 10; op_e[0] = 0;
    op_a[1] = 5;  op_b[1] = 4;  op_e[1] = 1;
    op_a[2] = -2; op_b[2] = 3;  op_e[2] = 1;
    op_a[3] = 1;  op_b[3] = 1;  op_e[3] = 0;
    clear_q();
    drive_stream(4, a0);
    repeat (8) @(posedge clk);
    chk_stream("b2b_def", q_def, c_def, a0, 2);
    chk_stream("b2b_n1", q_n1, c_n1, a0, 1);
    chk_stream("b2b_n4", q_n4, c_n4, a0, 4);

    // Backpressure: 6 ops, out_ready low for 3 cycles once the first result shows
    op_a[0] = 1;   op_b[0] = 2;  op_e[0] = 0;
    op_a[1] = 3;   op_b[1] = 4;  op_e[1] = 1;
    op_a[2] = 5;   op_b[2] = 6;  op_e[2] = 1;
    op_a[3] = 7;   op_b[3] = 8;  op_e[3] = 0;
    op_a[4] = 9;   op_b[4] = 10; op_e[4] = 1;
    op_a[5] = -11; op_b[5] = 12; op_e[5] = 1;
    exp5 = '{2, 14, 44, 56, 146, 14};
    clear_q();
    fork
      begin
        k = 0; g = 0;
        while (k < 6 && g < 100) begin
          @(posedge clk); #1;
          in_valid = 1'b1; din0 = op_a[k]; din1 = 13'(op_b[k]); acc_en = op_e[k];
          @(negedge clk);
          if (ir_def) k++;
          g++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      begin
        g = 0;
        do begin
          @(posedge clk); #1;
          g++;
        end while (!ov_def && g < 50);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", longint'(ir_def), 0);
          chk("stall_out_valid", longint'(ov_def), 1);
          chk("stall_dout", longint'($signed(dout_def)), 2);
          @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
      end
    join
    g = 0;
    while (q_def.size() < 6 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("bp_count", q_def.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < q_def.size()) chk($sformatf("bp_val%0d", i), q_def[i], exp5[i]);
    repeat (6) @(posedge clk);

    // Reset with two ops in flight
    @(posedge clk); #1;
    in_valid = 1'b1; din0 = 5; din1 = 13'(5); acc_en = 1'b0;
    @(posedge clk); #1;
    din0 = 6; din1 = 13'(6); acc_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_ov_def", longint'(ov_def), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_flight_ov_def", longint'(ov_def), 0);
    chk("rst_flight_ov_n4", longint'(ov_n4), 0);
    chk("rst_flight_dout_def", longint'(dout_def), 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    clear_q();
    repeat (8) @(posedge clk);
    chk("no_stale_def", q_def.size(), 0);
    chk("no_stale_n4", q_n4.size(), 0);
    op_a[0] = 7; op_b[0] = 3; op_e[0] = 1;
    drive_stream(1, a0);
    repeat (8) @(posedge clk);
    chk("post_rst_count_def", q_def.size(), 1);
    chk("post_rst_count_n1", q_n1.size(), 1);
    chk("post_rst_count_n4", q_n4.size(), 1);
    if (q_def.size() > 0) chk("post_rst_def", q_def[0], 21);
    if (q_n1.size() > 0)  chk("post_rst_n1", q_n1[0], 21);
    if (q_n4.size() > 0) begin
      chk("post_rst_n4", q_n4[0], 21);
      chk("post_rst_n4_cyc", c_n4[0], a0 + 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
